// File: rtl/cv32e40p_conv_tile_engine.sv
// 3x3 convolution tile engine: loads NUM_CH 4x4 tiles, produces a 2x2 output tile with optional ReLU / 2x2 max-pool.
// Define CONV_SAT_EN for saturating output conversion; otherwise the conversion wraps to DATA_W bits.
module cv32e40p_conv_tile_engine #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 1,
  parameter int SHIFT  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic                        w_we_i,
  input  logic [$clog2(9*NUM_CH)-1:0] w_addr_i,
  input  logic [DATA_W-1:0]           w_data_i,
  input  logic                        in_valid_i,
  input  logic [DATA_W-1:0]           in_data_i,
  output logic                        in_ready_o,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic                        out_last_o,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);
  localparam int NW    = 9 * NUM_CH;
  localparam int NX    = 16 * NUM_CH;
  localparam int WA    = $clog2(NW);
  localparam int XW    = $clog2(NX);
  localparam int ACC_W = 2 * DATA_W + 6;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_POST, S_DRAIN} state_t;

  state_t                    r_state;
  logic [1:0]                r_mode;
  logic signed [DATA_W-1:0]  r_w   [NW];
  logic signed [DATA_W-1:0]  r_x   [NX];
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_res [4];
  logic signed [DATA_W-1:0]  r_out [4];
  logic [XW-1:0]             r_xcnt;
  logic [WA-1:0]             r_k;
  logic [1:0]                r_i, r_j, r_ch, r_o, r_oidx;
  logic                      r_out_valid, r_out_last, r_done, r_err;
  logic [DATA_W-1:0]         r_out_data;

  logic [XW-1:0]             w_xaddr;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [DATA_W-1:0]  w_post [4];
  logic signed [DATA_W-1:0]  w_best;
  logic                      w_relu, w_pool;

  // Sample index of x[ch][r+i][c+j] for the output currently being accumulated
  always_comb begin
    w_xaddr    = XW'(32'(r_ch) * 32'd16 + (32'(r_o[1]) + 32'(r_i)) * 32'd4 + 32'(r_o[0]) + 32'(r_j));
    w_prod     = r_x[w_xaddr] * r_w[r_k];
    w_acc_next = r_acc + ACC_W'(w_prod);
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] w_sh;
`endif

  always_comb begin
    w_relu = (r_mode == 2'd1) || (r_mode == 2'd2);
    w_pool = r_mode[1];
    w_post = '{default: '0};
`ifdef CONV_SAT_EN
    w_sh   = '0;
`endif
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef CONV_SAT_EN
      w_sh = r_res[k] >>> SHIFT;
      if (w_sh > SAT_HI)      w_post[k] = DATA_W'(SAT_HI);
      else if (w_sh < SAT_LO) w_post[k] = DATA_W'(SAT_LO);
      else                    w_post[k] = DATA_W'(w_sh);
`else
      w_post[k] = DATA_W'(r_res[k] >>> SHIFT);
`endif
      if (w_relu && w_post[k][DATA_W-1]) w_post[k] = '0;
    end
    // Strict compare keeps the lowest index on ties
    w_best = w_post[0];
    for (int unsigned k = 1; k < 4; k++)
      if (w_post[k] > w_best) w_best = w_post[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      for (int unsigned k = 0; k < NW; k++) r_w[k] <= '0;
      for (int unsigned k = 0; k < NX; k++) r_x[k] <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        r_res[k] <= '0;
        r_out[k] <= '0;
      end
      r_acc       <= '0;
      r_xcnt      <= '0;
      r_k         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_ch        <= '0;
      r_o         <= '0;
      r_oidx      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_we_i) begin
        if (r_state == S_IDLE && w_addr_i < WA'(NW)) r_w[w_addr_i] <= w_data_i;
        else                                         r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (start_i) begin
          r_mode  <= mode_i;
          r_xcnt  <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: if (in_valid_i) begin
          r_x[r_xcnt] <= in_data_i;
          r_xcnt      <= r_xcnt + 1'b1;
          if (r_xcnt == XW'(NX - 1)) begin
            r_acc   <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_ch    <= '0;
            r_o     <= '0;
            r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (r_k == WA'(NW - 1)) begin
            r_res[r_o] <= w_acc_next;
            r_acc      <= '0;
            r_k        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_ch       <= '0;
            r_o        <= r_o + 1'b1;
            if (r_o == 2'd3) r_state <= S_POST;
          end else begin
            r_acc <= w_acc_next;
            r_k   <= r_k + 1'b1;
            if (r_j == 2'd2) begin
              r_j <= '0;
              if (r_i == 2'd2) begin
                r_i  <= '0;
                r_ch <= r_ch + 1'b1;
              end else r_i <= r_i + 1'b1;
            end else r_j <= r_j + 1'b1;
          end
        end
        S_POST: begin
          r_out       <= w_post;
          r_out_data  <= w_pool ? w_best : w_post[0];
          r_out_last  <= w_pool;
          r_out_valid <= 1'b1;
          r_oidx      <= '0;
          r_state     <= S_DRAIN;
        end
        S_DRAIN: if (out_ready_i) begin
          if (r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_oidx     <= r_oidx + 1'b1;
            r_out_data <= r_out[r_oidx + 2'd1];
            r_out_last <= (r_oidx == 2'd2);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == S_LOAD);
  assign busy_o      = (r_state != S_IDLE);
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign done_o      = r_done;
  assign err_o       = r_err;
endmodule
